wb_csr_slave: RTL and testbench
===============================

WB_CSR_SLAVE -- requirements
Module: wb_csr_slave

Interface
REQ-001 SHALL have parameter DATA, default 32, meaning data width; only 32 is supported.
REQ-002 SHALL have parameter ADDR, default 32, meaning Wishbone address width.
REQ-003 SHALL have parameter STRB, default DATA/8, meaning byte-select width; it is derived and not overridden.
REQ-004 SHALL have parameter ID_VALUE, default 32'h510E0001, meaning the constant returned by the ID register.
REQ-005 SHALL have parameter CTRL_RESET, default 0, meaning the reset value of CTRL.
REQ-006 SHALL have port wb_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port wb_cyc_i, input, 1 bit: bus cycle.
REQ-009 SHALL have port wb_stb_i, input, 1 bit: strobe.
REQ-010 SHALL have port wb_we_i, input, 1 bit: write enable.
REQ-011 SHALL have port wb_adr_i, input, ADDR bits: byte address.
REQ-012 SHALL have port wb_dat_i, input, DATA bits: write data.
REQ-013 SHALL have port wb_sel_i, input, STRB bits: byte selects.
REQ-014 SHALL have port wb_dat_o, output, DATA bits: read data.
REQ-015 SHALL have port wb_ack_o, output, 1 bit: access acknowledge.
REQ-016 SHALL have port wb_err_o, output, 1 bit: unmapped-access error.
REQ-017 SHALL have port wb_stall_o, output, 1 bit: high while a response is pending.
REQ-018 SHALL have port ctrl_o, output, 32 bits: CTRL register contents.
REQ-019 SHALL have port status_i, input, 32 bits: live status word.
REQ-020 SHALL have port event_i, input, 32 bits: per-bit event pulses.
REQ-021 SHALL have port cnt_inc_i, input, 1 bit: counter increment strobe.
REQ-022 SHALL have port irq_o, output, 1 bit: level interrupt.

Function
REQ-023 SHALL decode the register offset from wb_adr_i[7:2], ignore wb_adr_i[1:0], and ignore all bits above bit 7.
REQ-024 SHALL implement this map: 0x00 ID (RO), 0x04 CTRL (RW), 0x08 STATUS (RO), 0x0C EVENT (W1C), 0x10 IRQ_MASK (RW), 0x14 COUNT (RO; any write clears it), 0x18 SCRATCH (RW).
REQ-025 SHALL use FSM states IDLE and RESP.
REQ-026 SHALL move IDLE->RESP on any cycle in IDLE where wb_cyc_i&wb_stb_i is high, and RESP->IDLE unconditionally after one cycle.
REQ-027 SHALL commit a write and capture read data in the IDLE cycle in which the access is sampled.
REQ-028 SHALL drive wb_ack_o (mapped offset) or wb_err_o (unmapped offset) high for exactly the one RESP cycle, giving 1-cycle latency; ack and err are never both high.
REQ-029 SHALL hold wb_dat_o valid during the RESP cycle only and drive it to 0 at all other times, including for errored reads and for writes.
REQ-030 SHALL drive wb_stall_o high in RESP and ignore wb_stb_i in RESP; an access is re-sampled only in IDLE.
REQ-031 SHALL apply writes to RW registers per byte: byte n is updated only if wb_sel_i[n] is high.
REQ-032 SHALL ignore writes to RO registers, which still get an ack, and SHALL leave all registers unchanged on unmapped writes.
REQ-033 SHALL return, on an ID read, ID_VALUE.
REQ-034 SHALL return, on a STATUS read, status_i as sampled in the access cycle.
REQ-035 SHALL make EVENT bits sticky: bit n sets when event_i[n] is high.
REQ-036 SHALL clear EVENT bit n on a write with wb_dat_i[n]=1 and its byte selected; if set and clear coincide on the same bit, set wins.
REQ-037 SHALL increment COUNT by 1 on each cycle cnt_inc_i is high, saturating at 32'hFFFFFFFF with no wrap.
REQ-038 SHALL clear COUNT to 0 on a COUNT write regardless of wb_sel_i; clear wins over a coincident increment.
REQ-039 SHALL register irq_o as |(EVENT & IRQ_MASK), so irq_o follows one cycle after the register change.
REQ-040 SHALL drive ctrl_o directly from the CTRL register.

Reset
REQ-041 SHALL, on rst high at a clock edge, set the FSM to IDLE and set wb_ack_o, wb_err_o, wb_stall_o, wb_dat_o and irq_o to 0.
REQ-042 SHALL, on reset, set CTRL to CTRL_RESET and set EVENT, IRQ_MASK, COUNT and SCRATCH to 0.
REQ-043 SHALL, when reset is asserted during RESP, suppress the pending ack or err and produce no response for that access.
REQ-044 SHALL ignore bus accesses while rst is high.

Verification
REQ-045 SHALL cover: read 0x00 -> ack exactly one cycle after stb is sampled, wb_dat_o=32'h510E0001, stall high for that cycle.
REQ-046 SHALL cover: write 0x18 with data 32'hAABBCCDD, sel 4'b0101, then read -> 32'h00BB00DD.
REQ-047 SHALL cover: read 0x40 -> wb_err_o for one cycle, wb_ack_o=0, wb_dat_o=0; a write to 0x40 changes no register.
REQ-048 SHALL cover: event_i[3] pulse, IRQ_MASK=32'h8 -> irq_o=1; write 0x0C with 32'h8 in the same cycle as another event_i[3] pulse -> EVENT[3] stays 1; a later clear alone -> irq_o=0 one cycle after.
REQ-049 SHALL cover: hold cnt_inc_i high from COUNT=32'hFFFFFFFE for 3 cycles -> 32'hFFFFFFFF; write 0x14 while cnt_inc_i=1 -> reads 0.
REQ-050 SHALL cover: assert rst in the RESP cycle -> no ack and no err that cycle, and CTRL reads back CTRL_RESET afterwards.

Source files
------------

// File: rtl/wb_csr_slave.sv
// Wishbone CSR slave: ID, CTRL, STATUS, sticky EVENT, IRQ_MASK, saturating COUNT and SCRATCH.
// Single-beat access with a one-cycle response and a level interrupt.
`timescale 1ns/1ps
module wb_csr_slave #(
    parameter int unsigned DATA       = 32,
    parameter int unsigned ADDR       = 32,
    parameter int unsigned STRB       = DATA / 8,
    parameter logic [31:0] ID_VALUE   = 32'h510E0001,
    parameter logic [31:0] CTRL_RESET = 32'h0
) (
    input  logic            wb_clk,
    input  logic            rst,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic            wb_we_i,
    input  logic [ADDR-1:0] wb_adr_i,
    input  logic [DATA-1:0] wb_dat_i,
    input  logic [STRB-1:0] wb_sel_i,
    output logic [DATA-1:0] wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic            wb_stall_o,
    output logic [31:0]     ctrl_o,
    input  logic [31:0]     status_i,
    input  logic [31:0]     event_i,
    input  logic            cnt_inc_i,
    output logic            irq_o
);

    localparam logic [5:0] OFF_ID      = 6'd0;
    localparam logic [5:0] OFF_CTRL    = 6'd1;
    localparam logic [5:0] OFF_STATUS  = 6'd2;
    localparam logic [5:0] OFF_EVENT   = 6'd3;
    localparam logic [5:0] OFF_MASK    = 6'd4;
    localparam logic [5:0] OFF_COUNT   = 6'd5;
    localparam logic [5:0] OFF_SCRATCH = 6'd6;

    typedef enum logic {IDLE, RESP} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_ctrl;
    logic [31:0]     r_event;
    logic [31:0]     r_mask;
    logic [31:0]     r_count;
    logic [31:0]     r_scratch;
    logic            r_ack;
    logic            r_err;
    logic            r_stall;
    logic [DATA-1:0] r_dat;
    logic            r_irq;

    logic [5:0]      w_off;
    logic            w_acc;
    logic            w_wr;
    logic            w_mapped;
    logic [DATA-1:0] w_rdata;
    logic [DATA-1:0] w_bmask;
    logic [31:0]     w_ev_clr;
    logic            w_cnt_clr;
    logic            w_ack_nxt;
    logic            w_err_nxt;
    logic            w_stall_nxt;
    logic [DATA-1:0] w_dat_nxt;
    logic            w_unused;

    assign w_off    = wb_adr_i[7:2];
    assign w_unused = ^{wb_adr_i[ADDR-1:8], wb_adr_i[1:0]};
    assign w_acc    = (r_state == IDLE) && wb_cyc_i && wb_stb_i;
    assign w_wr     = w_acc && wb_we_i;

    // Byte-select expansion to a bit mask
    always_comb begin
        w_bmask = '0;
        for (int i = 0; i < int'(STRB); i++) begin
            w_bmask[i*8 +: 8] = {8{wb_sel_i[i]}};
        end
    end

    // Register read mux and address decode
    always_comb begin
        w_rdata  = '0;
        w_mapped = 1'b1;
        case (w_off)
            OFF_ID:      w_rdata = ID_VALUE;
            OFF_CTRL:    w_rdata = r_ctrl;
            OFF_STATUS:  w_rdata = status_i;
            OFF_EVENT:   w_rdata = r_event;
            OFF_MASK:    w_rdata = r_mask;
            OFF_COUNT:   w_rdata = r_count;
            OFF_SCRATCH: w_rdata = r_scratch;
            default:     w_mapped = 1'b0;
        endcase
    end

    assign w_ev_clr  = (w_wr && (w_off == OFF_EVENT)) ? (wb_dat_i & w_bmask) : 32'h0;
    assign w_cnt_clr = w_wr && (w_off == OFF_COUNT);

    // FSM next state and next response values
    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_stall_nxt = 1'b0;
        w_dat_nxt   = '0;
        case (r_state)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    w_state_nxt = RESP;
                    w_stall_nxt = 1'b1;
                    w_ack_nxt   = w_mapped;
                    w_err_nxt   = !w_mapped;
                    w_dat_nxt   = (w_mapped && !wb_we_i) ? w_rdata : '0;
                end
            end
            RESP: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_stall <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_stall <= w_stall_nxt;
            r_dat   <= w_dat_nxt;
        end
    end

    // CSR storage; writes commit in the sampling cycle
    always_ff @(posedge wb_clk) begin
        if (rst) begin
            r_ctrl    <= CTRL_RESET;
            r_event   <= 32'h0;
            r_mask    <= 32'h0;
            r_count   <= 32'h0;
            r_scratch <= 32'h0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr && (w_off == OFF_CTRL)) begin
                r_ctrl <= (r_ctrl & ~w_bmask) | (wb_dat_i & w_bmask);
            end
            if (w_wr && (w_off == OFF_MASK)) begin
                r_mask <= (r_mask & ~w_bmask) | (wb_dat_i & w_bmask);
            end
            if (w_wr && (w_off == OFF_SCRATCH)) begin
                r_scratch <= (r_scratch & ~w_bmask) | (wb_dat_i & w_bmask);
            end
            r_event <= (r_event & ~w_ev_clr) | event_i;
            if (w_cnt_clr) begin
                r_count <= 32'h0;
            end else if (cnt_inc_i && (r_count != 32'hFFFF_FFFF)) begin
                r_count <= r_count + 32'd1;
            end
            r_irq <= |(r_event & r_mask);
        end
    end

    // A reset landing in the response cycle cancels the pending handshake
    assign wb_ack_o   = r_ack & ~rst;
    assign wb_err_o   = r_err & ~rst;
    assign wb_stall_o = r_stall;
    assign wb_dat_o   = r_dat;
    assign ctrl_o     = r_ctrl;
    assign irq_o      = r_irq;

endmodule

// File: tb/tb_wb_csr_slave.sv
// Directed bench for wb_csr_slave: register-map vector table plus event, counter and reset sequences.
`timescale 1ns/1ps
module tb_wb_csr_slave;

    localparam logic [31:0] ID       = 32'h510E0001;
    localparam logic [31:0] CTRL_RST = 32'h0000_5A00;
    localparam logic [31:0] STATUS   = 32'hCAFE_F00D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] adr = 32'h0;
    logic [31:0] wdat = 32'h0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] rdat;
    logic        ack;
    logic        err;
    logic        stall;
    logic [31:0] ctrl;
    logic [31:0] status = STATUS;
    logic [31:0] evt = 32'h0;
    logic        cnt_inc = 1'b0;
    logic        irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_csr_slave #(.CTRL_RESET(CTRL_RST)) dut (
        .wb_clk    (clk),
        .rst       (rst),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_we_i   (we),
        .wb_adr_i  (adr),
        .wb_dat_i  (wdat),
        .wb_sel_i  (sel),
        .wb_dat_o  (rdat),
        .wb_ack_o  (ack),
        .wb_err_o  (err),
        .wb_stall_o(stall),
        .ctrl_o    (ctrl),
        .status_i  (status),
        .event_i   (evt),
        .cnt_inc_i (cnt_inc),
        .irq_o     (irq)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        ack;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    endtask

    task automatic idle_bus();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'h0; wdat = 32'h0; sel = 4'h0;
    endtask

    // One access: drive on negedge, sample the response cycle 1ns after the edge
    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic o_ack, output logic o_err, output logic o_stall, output logic [31:0] o_rd);
        @(negedge clk);
        drive(w, a, d, s);
        @(posedge clk);
        #1;
        o_ack = ack; o_err = err; o_stall = stall; o_rd = rdat;
        @(negedge clk);
        idle_bus();
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic k, e, st;
        logic [31:0] r;
        bus(1'b0, a, 32'h0, 4'hF, k, e, st, r);
        chk({name, "_ack"}, 32'(k), 32'd1);
        chk({name, "_dat"}, r, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic k, e, st;
        logic [31:0] r;
        bus(1'b1, a, d, s, k, e, st, r);
        chk("wr_ack", 32'(k), 32'd1);
    endtask

    initial begin
        logic k, e, st;
        logic [31:0] r;

        vecs.push_back('{1'b0, 32'h00,  32'h0,         4'hF, 1'b1, 1'b0, ID});
        vecs.push_back('{1'b0, 32'h04,  32'h0,         4'hF, 1'b1, 1'b0, CTRL_RST});
        vecs.push_back('{1'b1, 32'h04,  32'h12345678,  4'hF, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h04,  32'h0,         4'hF, 1'b1, 1'b0, 32'h12345678});
        vecs.push_back('{1'b1, 32'h04,  32'hFFFFFFFF,  4'h8, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h04,  32'h0,         4'hF, 1'b1, 1'b0, 32'hFF345678});
        vecs.push_back('{1'b1, 32'h18,  32'hAABBCCDD,  4'h5, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h18,  32'h0,         4'hF, 1'b1, 1'b0, 32'h00BB00DD});
        vecs.push_back('{1'b0, 32'h40,  32'h0,         4'hF, 1'b0, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'h40,  32'hFFFFFFFF,  4'hF, 1'b0, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'h18,  32'h0,         4'hF, 1'b1, 1'b0, 32'h00BB00DD});
        vecs.push_back('{1'b0, 32'h04,  32'h0,         4'hF, 1'b1, 1'b0, 32'hFF345678});
        vecs.push_back('{1'b1, 32'h00,  32'hDEADBEEF,  4'hF, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h00,  32'h0,         4'hF, 1'b1, 1'b0, ID});
        vecs.push_back('{1'b1, 32'h08,  32'hFFFFFFFF,  4'hF, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h08,  32'h0,         4'hF, 1'b1, 1'b0, STATUS});
        vecs.push_back('{1'b0, 32'h107, 32'h0,         4'hF, 1'b1, 1'b0, 32'hFF345678});
        vecs.push_back('{1'b0, 32'h10,  32'h0,         4'hF, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h14,  32'h0,         4'hF, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h1C,  32'h0,         4'hF, 1'b0, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'h0C,  32'h0,         4'hF, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 32'h10,  32'h12345678,  4'h3, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h10,  32'h0,         4'hF, 1'b1, 1'b0, 32'h00005678});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_dat", rdat, 32'h0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_ctrl", ctrl, CTRL_RST);
        @(negedge clk);
        rst = 1'b0;

        // Register map vectors
        foreach (vecs[i]) begin
            bus(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, k, e, st, r);
            chk($sformatf("vec%0d_ack", i), 32'(k), 32'(vecs[i].ack));
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].err));
            chk($sformatf("vec%0d_stall", i), 32'(st), 32'd1);
            chk($sformatf("vec%0d_dat", i), r, vecs[i].rd);
        end
        chk("ctrl_o", ctrl, 32'hFF345678);

        // Held strobe: one ack, ignored in RESP, re-sampled in IDLE
        @(negedge clk);
        drive(1'b0, 32'h00, 32'h0, 4'hF);
        @(posedge clk); #1;
        chk("hold_ack1", 32'(ack), 32'd1);
        chk("hold_dat1", rdat, ID);
        @(posedge clk); #1;
        chk("hold_ack2", 32'(ack), 32'd0);
        chk("hold_stall2", 32'(stall), 32'd0);
        chk("hold_dat2", rdat, 32'h0);
        @(posedge clk); #1;
        chk("hold_ack3", 32'(ack), 32'd1);
        @(negedge clk);
        idle_bus();

        // Sticky events and interrupt
        wr(32'h10, 32'h8, 4'hF);
        @(negedge clk);
        evt = 32'h8;
        @(posedge clk); #1;
        chk("irq_lag", 32'(irq), 32'd0);
        @(negedge clk);
        evt = 32'h0;
        @(posedge clk); #1;
        chk("irq_set", 32'(irq), 32'd1);
        @(negedge clk);
        drive(1'b1, 32'h0C, 32'h8, 4'hF);
        evt = 32'h8;
        @(posedge clk); #1;
        chk("ev_coinc_ack", 32'(ack), 32'd1);
        @(negedge clk);
        idle_bus();
        evt = 32'h0;
        rd_chk("ev_set_wins", 32'h0C, 32'h8);
        chk("irq_still", 32'(irq), 32'd1);
        wr(32'h0C, 32'h8, 4'hE);
        rd_chk("ev_unsel", 32'h0C, 32'h8);
        @(negedge clk);
        drive(1'b1, 32'h0C, 32'h8, 4'h1);
        @(posedge clk); #1;
        chk("irq_pre_clr", 32'(irq), 32'd1);
        @(negedge clk);
        idle_bus();
        @(posedge clk); #1;
        chk("irq_clr", 32'(irq), 32'd0);
        rd_chk("ev_cleared", 32'h0C, 32'h0);

        // Counter increment, saturation and clear
        @(negedge clk);
        cnt_inc = 1'b1;
        repeat (3) @(negedge clk);
        cnt_inc = 1'b0;
        rd_chk("cnt3", 32'h14, 32'd3);
        @(negedge clk);
        force dut.r_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_count;
        @(negedge clk);
        cnt_inc = 1'b1;
        repeat (3) @(negedge clk);
        cnt_inc = 1'b0;
        rd_chk("cnt_sat", 32'h14, 32'hFFFF_FFFF);
        @(negedge clk);
        drive(1'b1, 32'h14, 32'h1234, 4'h0);
        cnt_inc = 1'b1;
        @(posedge clk); #1;
        chk("cnt_clr_ack", 32'(ack), 32'd1);
        @(negedge clk);
        idle_bus();
        cnt_inc = 1'b0;
        rd_chk("cnt_clr", 32'h14, 32'h0);

        // Reset during the response cycle
        wr(32'h04, 32'hA5A5A5A5, 4'hF);
        chk("ctrl_pre", ctrl, 32'hA5A5A5A5);
        @(negedge clk);
        drive(1'b0, 32'h04, 32'h0, 4'hF);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rresp_ack", 32'(ack), 32'd0);
        chk("rresp_err", 32'(err), 32'd0);
        @(negedge clk);
        idle_bus();
        @(posedge clk); #1;
        chk("rresp_ack2", 32'(ack), 32'd0);
        chk("rresp_ctrl", ctrl, CTRL_RST);
        @(negedge clk);
        rst = 1'b0;
        rd_chk("ctrl_after_rst", 32'h04, CTRL_RST);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
